// File: rtl/types_pkg.sv
// Shared types for the retirement trace path: the packed trace record and
// the helper that builds one from the retire-stage signals.
package types_pkg;

    localparam int TRACE_SEQ_W = 32;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [31:0]            pc;
        logic                   rd_we;
        logic [4:0]             rd;
        logic [31:0]            rd_data;
        logic                   mem_we;
        logic                   mem_re;
        logic [31:0]            mem_addr;
        logic [31:0]            mem_data;
        logic [3:0]             mem_be;
    } trace_rec_t;

    // Writes to x0 are architecturally invisible, so they are traced as no-writes.
    function automatic trace_rec_t pack_trace_rec(
        input logic [TRACE_SEQ_W-1:0] seq,
        input logic [31:0]            pc,
        input logic                   rd_we,
        input logic [4:0]             rd,
        input logic [31:0]            rd_data,
        input logic                   mem_we,
        input logic                   mem_re,
        input logic [31:0]            mem_addr,
        input logic [31:0]            mem_data,
        input logic [3:0]             mem_be
    );
        trace_rec_t r;
        logic       we_eff;
        we_eff     = rd_we & (rd != 5'd0);
        r.seq      = seq;
        r.pc       = pc;
        r.rd_we    = we_eff;
        r.rd       = rd;
        r.rd_data  = we_eff ? rd_data : 32'd0;
        r.mem_we   = mem_we;
        r.mem_re   = mem_re;
        r.mem_addr = mem_addr;
        r.mem_data = mem_data;
        r.mem_be   = mem_be;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; pointers carry one wrap bit so full and empty
// are told apart by the MSB, and the head entry reads as zero when empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_writer.sv
// Retirement trace writer: packs one record per retired instruction, tags it
// with a sequence number and buffers it for a valid/ready reader.
module retire_trace_writer
    import types_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ret_valid,
    input  logic [31:0]              ret_pc,
    input  logic                     ret_rd_we,
    input  logic [4:0]               ret_rd,
    input  logic [31:0]              ret_rd_data,
    input  logic                     ret_mem_we,
    input  logic                     ret_mem_re,
    input  logic [31:0]              ret_mem_addr,
    input  logic [31:0]              ret_mem_data,
    input  logic [3:0]               ret_mem_be,
    input  logic                     flush,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output trace_rec_t               trc_rec,
    output logic                     trc_overflow,
    output logic [CNT_W-1:0]         trc_drop_cnt,
    output logic [$clog2(DEPTH):0]   trc_level
);

    logic [TRACE_SEQ_W-1:0] seq;
    trace_rec_t             rec_in;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   drop;

    assign rec_in = pack_trace_rec(seq, ret_pc, ret_rd_we, ret_rd, ret_rd_data,
                                   ret_mem_we, ret_mem_re, ret_mem_addr,
                                   ret_mem_data, ret_mem_be);

    assign trc_valid = ~fifo_empty;
    assign pop       = trc_valid & trc_ready;
    assign drop      = ret_valid & fifo_full & ~pop & ~flush;

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_valid),
        .pop   (pop),
        .flush (flush),
        .din   (rec_in),
        .dout  (trc_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (trc_level)
    );

    // Every retirement consumes a number, even dropped or flushed ones, so gaps are visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= '0;
        end else if (ret_valid) begin
            seq <= seq + TRACE_SEQ_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trc_overflow <= 1'b0;
            trc_drop_cnt <= '0;
        end else if (flush) begin
            trc_overflow <= 1'b0;
            trc_drop_cnt <= '0;
        end else if (drop) begin
            trc_overflow <= 1'b1;
            if (trc_drop_cnt != '1) trc_drop_cnt <= trc_drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_retire_trace_writer.sv
// Directed bench for retire_trace_writer: a vector table for basic record
// handling plus hand-written overflow, flush and async-reset sequences.
module tb_retire_trace_writer;
    import types_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 3;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ret_valid;
    logic [31:0]       ret_pc;
    logic              ret_rd_we;
    logic [4:0]        ret_rd;
    logic [31:0]       ret_rd_data;
    logic              ret_mem_we;
    logic              ret_mem_re;
    logic [31:0]       ret_mem_addr;
    logic [31:0]       ret_mem_data;
    logic [3:0]        ret_mem_be;
    logic              flush;
    logic              trc_valid;
    logic              trc_ready;
    trace_rec_t        trc_rec;
    logic              trc_overflow;
    logic [CNT_W-1:0]  trc_drop_cnt;
    logic [LW-1:0]     trc_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_trace_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_rd_we    (ret_rd_we),
        .ret_rd       (ret_rd),
        .ret_rd_data  (ret_rd_data),
        .ret_mem_we   (ret_mem_we),
        .ret_mem_re   (ret_mem_re),
        .ret_mem_addr (ret_mem_addr),
        .ret_mem_data (ret_mem_data),
        .ret_mem_be   (ret_mem_be),
        .flush        (flush),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_rec      (trc_rec),
        .trc_overflow (trc_overflow),
        .trc_drop_cnt (trc_drop_cnt),
        .trc_level    (trc_level)
    );

    typedef struct packed {
        logic        ret_valid;
        logic [31:0] pc;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        mem_we;
        logic        mem_re;
        logic [31:0] addr;
        logic [31:0] mdata;
        logic [3:0]  be;
        logic        flush;
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       exp_valid;
        trace_rec_t exp_rec;
        int         exp_level;
        int         exp_drop;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    function automatic stim_t st(input logic v, input logic [31:0] pc, input logic we,
                                 input logic [4:0] rd, input logic [31:0] d,
                                 input logic mw, input logic mr, input logic [31:0] a,
                                 input logic [31:0] md, input logic [3:0] be,
                                 input logic fl, input logic rdy);
        stim_t s;
        s = '{v, pc, we, rd, d, mw, mr, a, md, be, fl, rdy};
        return s;
    endfunction

    function automatic stim_t idle(input logic rdy);
        return st(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, rdy);
    endfunction

    function automatic trace_rec_t rec(input logic [31:0] seq, input logic [31:0] pc,
                                       input logic we, input logic [4:0] rd,
                                       input logic [31:0] d, input logic mw, input logic mr,
                                       input logic [31:0] a, input logic [31:0] md,
                                       input logic [3:0] be);
        trace_rec_t r;
        r = '{seq, pc, we, rd, d, mw, mr, a, md, be};
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        ret_valid    = s.ret_valid;
        ret_pc       = s.pc;
        ret_rd_we    = s.rd_we;
        ret_rd       = s.rd;
        ret_rd_data  = s.rd_data;
        ret_mem_we   = s.mem_we;
        ret_mem_re   = s.mem_re;
        ret_mem_addr = s.addr;
        ret_mem_data = s.mdata;
        ret_mem_be   = s.be;
        flush        = s.flush;
        trc_ready    = s.ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic exp_valid, input trace_rec_t exp_rec,
                               input int exp_level, input int exp_drop, input logic exp_ovf);
        checkVal({name, ".valid"}, trc_valid, exp_valid);
        checkVal({name, ".level"}, trc_level, exp_level);
        checkVal({name, ".drop"}, trc_drop_cnt, exp_drop);
        checkVal({name, ".ovf"}, trc_overflow, exp_ovf);
        if (exp_valid) checkVal({name, ".rec"}, trc_rec, exp_rec);
    endtask

    task automatic checkAllZero(input string name);
        checkVal({name, ".valid"}, trc_valid, 0);
        checkVal({name, ".rec"}, trc_rec, 0);
        checkVal({name, ".level"}, trc_level, 0);
        checkVal({name, ".drop"}, trc_drop_cnt, 0);
        checkVal({name, ".ovf"}, trc_overflow, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(idle(1'b0));
        checkAllZero("reset");
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(ret_mem_we && ret_mem_re))
                else $error("[TB] illegal stimulus: load and store together");
            assert (!(trc_valid && trc_rec.mem_we && trc_rec.mem_re))
                else $error("[TB] record carries both load and store");
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{st(1, 32'h100, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1), 1,
                    rec(0, 32'h100, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0), 1, 0, 0};
        vecs[1] = '{idle(1), 0, '0, 0, 0, 0};
        vecs[2] = '{st(1, 32'h104, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0, 0), 1,
                    rec(1, 32'h104, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0), 1, 0, 0};
        vecs[3] = '{st(1, 32'h108, 0, 5'd3, 32'h77, 0, 1, 32'h3000, 32'hAB, 4'hF, 0, 0), 1,
                    rec(1, 32'h104, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0), 2, 0, 0};
        vecs[4] = '{idle(1), 1,
                    rec(2, 32'h108, 0, 5'd3, 32'h0, 0, 1, 32'h3000, 32'hAB, 4'hF), 1, 0, 0};
        vecs[5] = '{st(1, 32'h10C, 1, 5'd7, 32'h1234, 1, 0, 32'h2000, 32'hCAFE, 4'b0011, 0, 1), 1,
                    rec(3, 32'h10C, 1, 5'd7, 32'h1234, 1, 0, 32'h2000, 32'hCAFE, 4'b0011), 1, 0, 0};
        vecs[6] = '{idle(1), 0, '0, 0, 0, 0};
        vecs[7] = '{st(1, 32'h110, 1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0), 1,
                    rec(4, 32'h110, 1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 0), 1, 0, 0};
        vecs[8] = '{idle(0), 1,
                    rec(4, 32'h110, 1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 0), 1, 0, 0};
        vecs[9] = '{idle(1), 0, '0, 0, 0, 0};

        rst = 1'b1;
        ret_valid = 0; ret_pc = 0; ret_rd_we = 0; ret_rd = 0; ret_rd_data = 0;
        ret_mem_we = 0; ret_mem_re = 0; ret_mem_addr = 0; ret_mem_data = 0; ret_mem_be = 0;
        flush = 0; trc_ready = 0;
        @(negedge clk);
        doReset();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_rec,
                        vecs[i].exp_level, vecs[i].exp_drop, vecs[i].exp_ovf);
        end

        // Overflow: ten retires into an eight-deep buffer with a stalled reader.
        doReset();
        for (int i = 0; i < 10; i++)
            applyStimulus(st(1, 32'h200 + 32'(4*i), 1, 5'(i+1), 32'h1000 + 32'(i), 0, 0, 0, 0, 0, 0, 0));
        checkOutput("ovf_full", 1, rec(0, 32'h200, 1, 5'd1, 32'h1000, 0, 0, 0, 0, 0), 8, 2, 1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain%0d", k), 1,
                        rec(32'(k), 32'h200 + 32'(4*k), 1, 5'(k+1), 32'h1000 + 32'(k), 0, 0, 0, 0, 0),
                        8 - k, 2, 1);
            applyStimulus(idle(1));
        end
        checkOutput("drained", 0, '0, 0, 2, 1);
        applyStimulus(st(1, 32'h300, 1, 5'd2, 32'h42, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("after_gap", 1, rec(10, 32'h300, 1, 5'd2, 32'h42, 0, 0, 0, 0, 0), 1, 2, 1);
        applyStimulus(idle(1));

        // Pop and push together on a full buffer: seq 11..18 fill, 19 enters as 11 leaves.
        for (int i = 0; i < 8; i++)
            applyStimulus(st(1, 32'h400 + 32'(4*i), 1, 5'(i+1), 32'(i), 0, 0, 0, 0, 0, 0, 0));
        checkOutput("pof_full", 1, rec(11, 32'h400, 1, 5'd1, 32'd0, 0, 0, 0, 0, 0), 8, 2, 1);
        applyStimulus(st(1, 32'h500, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 0, 1));
        checkOutput("pof_same", 1, rec(12, 32'h404, 1, 5'd2, 32'd1, 0, 0, 0, 0, 0), 8, 2, 1);
        for (int k = 0; k < 7; k++) applyStimulus(idle(1));
        checkOutput("pof_last", 1, rec(19, 32'h500, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0), 1, 2, 1);
        applyStimulus(idle(1));
        checkOutput("pof_empty", 0, '0, 0, 2, 1);

        // Drop counter saturation (seq 20..27 fill, 28..33 dropped).
        for (int i = 0; i < 13; i++)
            applyStimulus(st(1, 32'h600, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("sat7", 1, rec(20, 32'h600, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0), 8, 7, 1);
        applyStimulus(st(1, 32'h600, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("sat_hold", 1, rec(20, 32'h600, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0), 8, 7, 1);
        applyStimulus(st(1, 32'h604, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1, 0));
        checkOutput("flush_full", 0, '0, 0, 0, 0);
        applyStimulus(st(1, 32'h608, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0, 1));
        checkOutput("post_flush", 1, rec(35, 32'h608, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0), 1, 0, 0);
        applyStimulus(idle(1));

        // Store then flush-with-retire: the flushed retire still consumes seq 1.
        doReset();
        applyStimulus(st(1, 32'h700, 0, 5'd0, 32'd0, 1, 0, 32'h2000, 32'hBEEF, 4'b0011, 0, 0));
        checkOutput("store", 1, rec(0, 32'h700, 0, 5'd0, 32'd0, 1, 0, 32'h2000, 32'hBEEF, 4'b0011), 1, 0, 0);
        applyStimulus(st(1, 32'h704, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 1, 0));
        checkOutput("flush", 0, '0, 0, 0, 0);
        applyStimulus(st(1, 32'h708, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("flush_seq", 1, rec(2, 32'h708, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0), 1, 0, 0);
        applyStimulus(idle(1));

        // Asynchronous reset in the middle of a burst, between clock edges.
        for (int i = 0; i < 3; i++)
            applyStimulus(st(1, 32'h800 + 32'(4*i), 1, 5'd1, 32'h1, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("burst", 1, rec(3, 32'h800, 1, 5'd1, 32'h1, 0, 0, 0, 0, 0), 3, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        applyStimulus(idle(0));
        rst = 1'b0;
        applyStimulus(idle(0));
        checkAllZero("post_release");
        applyStimulus(st(1, 32'h900, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("first_after_rst", 1, rec(0, 32'h900, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0), 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
